// File: rtl/spike_history_recorder_if.sv
// Bus between the spike network and the recorder: spike vector and replay
// control in, layered window history, reward latch and push status out.
interface spike_history_recorder_if #(
   parameter int unsigned Neurons_Layer1 = 4,
   parameter int unsigned Neurons_Layer2 = 8,
   parameter int unsigned Neurons_Layer3 = 4,
   parameter int unsigned nHist          = 2
);
   localparam int unsigned Num_Neurons = Neurons_Layer1 + Neurons_Layer2 + Neurons_Layer3;
   localparam int unsigned CntW        = $clog2(nHist + 1);

   logic [Num_Neurons-1:0]          NetworkOutput;
   logic                            reward_in;
   logic                            start_replay_phase;
   logic                            finish_replay_phase;
   logic [nHist*Neurons_Layer1-1:0] InVecHst;
   logic [nHist*Neurons_Layer2-1:0] HippoVecHst;
   logic [nHist*Neurons_Layer3-1:0] OutVecHst;
   logic                            rewarded;
   logic [CntW-1:0]                 hist_count;
   logic                            hist_push;

   modport master (
      output NetworkOutput, reward_in, start_replay_phase, finish_replay_phase,
      input  InVecHst, HippoVecHst, OutVecHst, rewarded, hist_count, hist_push
   );

   modport slave (
      input  NetworkOutput, reward_in, start_replay_phase, finish_replay_phase,
      output InVecHst, HippoVecHst, OutVecHst, rewarded, hist_count, hist_push
   );
endinterface

// File: rtl/spike_history_recorder.sv
// Spike history recorder: OR-accumulates the spike vector per layer over a
// window of nWindow clocks and shifts each window result into an nHist-deep
// history. Capture freezes during replay and everything clears when replay
// finishes. Optional macro SPIKE_COUNT_THRESH_EN replaces the OR accumulator
// with per-neuron saturating counters compared against Spike_Thresh.
module spike_history_recorder #(
   parameter int unsigned Neurons_Layer1 = 4,
   parameter int unsigned Neurons_Layer2 = 8,
   parameter int unsigned Neurons_Layer3 = 4,
   parameter int unsigned nHist          = 2,
   parameter int unsigned nWindow        = 10,
   parameter int unsigned Spike_Thresh   = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   spike_history_recorder_if.slave bus
);
   localparam int unsigned L1 = Neurons_Layer1;
   localparam int unsigned L2 = Neurons_Layer2;
   localparam int unsigned L3 = Neurons_Layer3;
   localparam int unsigned NN = L1 + L2 + L3;
   localparam int unsigned CW = $clog2(nHist + 1);
   localparam int unsigned WW = (nWindow > 1) ? $clog2(nWindow) : 1;

   // A zero-length window or a threshold that can never be met is a config error.
   if (nWindow < 1 || Spike_Thresh < 1 || Spike_Thresh > nWindow) begin : g_param_check
      $error("spike_history_recorder: bad nWindow/Spike_Thresh");
   end

   logic [WW-1:0]        wcnt;
   logic                 capture;
   logic                 acc_clr;
   logic [NN-1:0]        win_vec;
   logic [nHist*L1-1:0]  in_next;
   logic [nHist*L2-1:0]  hippo_next;
   logic [nHist*L3-1:0]  out_next;

   // Capture on the last window slot unless frozen; finish overrides in the register block.
   always_comb begin
      capture = !bus.start_replay_phase && (wcnt == WW'(nWindow - 1));
      acc_clr = bus.finish_replay_phase || bus.start_replay_phase || capture;
   end

`ifdef SPIKE_COUNT_THRESH_EN
   localparam int unsigned SatW = $clog2(nWindow + 1);
   logic [SatW-1:0] cnt     [NN];
   logic [SatW-1:0] cnt_inc [NN];

   // Per-neuron count including this cycle's spike; a bit fires when the count reaches the threshold.
   always_comb begin
      win_vec = '0;
      for (int unsigned i = 0; i < NN; i++) begin
         cnt_inc[i] = cnt[i];
         if (bus.NetworkOutput[i] && (cnt[i] != '1)) cnt_inc[i] = cnt[i] + 1'b1;
         win_vec[i] = (32'(cnt_inc[i]) >= Spike_Thresh);
      end
   end

   // Saturating spike counters, cleared at capture, freeze, finish and reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NN; i++) cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NN; i++) cnt[i] <= acc_clr ? '0 : cnt_inc[i];
      end
   end
`else
   logic [NN-1:0] acc;

   // Window result includes the spikes of the current (possibly capture) cycle.
   always_comb begin
      win_vec = acc | bus.NetworkOutput;
   end

   // OR accumulator, cleared at capture, freeze, finish and reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) acc <= '0;
      else        acc <= acc_clr ? '0 : win_vec;
   end
`endif

   // Shifted history with the new window result as entry 0 of each layer.
   always_comb begin
      in_next                = bus.InVecHst << L1;
      in_next[L1-1:0]        = win_vec[L1-1:0];
      hippo_next             = bus.HippoVecHst << L2;
      hippo_next[L2-1:0]     = win_vec[L1+L2-1:L1];
      out_next               = bus.OutVecHst << L3;
      out_next[L3-1:0]       = win_vec[NN-1:L1+L2];
   end

   // Window counter, history, reward latch and push flag; finish beats freeze beats capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wcnt            <= '0;
         bus.InVecHst    <= '0;
         bus.HippoVecHst <= '0;
         bus.OutVecHst   <= '0;
         bus.rewarded    <= 1'b0;
         bus.hist_count  <= '0;
         bus.hist_push   <= 1'b0;
      end else if (bus.finish_replay_phase) begin
         wcnt            <= '0;
         bus.InVecHst    <= '0;
         bus.HippoVecHst <= '0;
         bus.OutVecHst   <= '0;
         bus.rewarded    <= 1'b0;
         bus.hist_count  <= '0;
         bus.hist_push   <= 1'b0;
      end else if (bus.start_replay_phase) begin
         wcnt          <= '0;
         bus.hist_push <= 1'b0;
      end else begin
         if (bus.reward_in) bus.rewarded <= 1'b1;
         if (capture) begin
            wcnt            <= '0;
            bus.InVecHst    <= in_next;
            bus.HippoVecHst <= hippo_next;
            bus.OutVecHst   <= out_next;
            bus.hist_push   <= 1'b1;
            if (bus.hist_count != CW'(nHist)) bus.hist_count <= bus.hist_count + 1'b1;
         end else begin
            wcnt          <= wcnt + 1'b1;
            bus.hist_push <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_spike_history_recorder.sv
// Scoreboard bench for spike_history_recorder (L1=4, L2=8, L3=4, nHist=2).
// Main DUT uses nWindow=10; a second instance uses nWindow=1.
module tb_spike_history_recorder;
   logic clk;
   logic reset;
   int unsigned edges;
   int unsigned tests;
   int unsigned fails;

   typedef struct {
      int unsigned at_edge;
      logic [7:0]  in_h;
      logic [15:0] hip_h;
      logic [7:0]  out_h;
      logic [1:0]  cnt;
      logic        rew;
   } exp_t;
   exp_t sb[$];

   spike_history_recorder_if #(.Neurons_Layer1(4), .Neurons_Layer2(8), .Neurons_Layer3(4), .nHist(2)) bus0 ();
   spike_history_recorder_if #(.Neurons_Layer1(4), .Neurons_Layer2(8), .Neurons_Layer3(4), .nHist(2)) bus1 ();

   spike_history_recorder #(
      .Neurons_Layer1(4), .Neurons_Layer2(8), .Neurons_Layer3(4),
      .nHist(2), .nWindow(10), .Spike_Thresh(2)
   ) dut (.clk(clk), .reset(reset), .bus(bus0));

   spike_history_recorder #(
      .Neurons_Layer1(4), .Neurons_Layer2(8), .Neurons_Layer3(4),
      .nHist(2), .nWindow(1), .Spike_Thresh(1)
   ) dut_w1 (.clk(clk), .reset(reset), .bus(bus1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) edges++;

   // Monitor: every push of the main DUT must match the oldest expectation.
   always @(negedge clk) begin
      if (reset && bus0.hist_push) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_push: push at edge %0d, none expected", edges);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (edges != e.at_edge || bus0.InVecHst !== e.in_h || bus0.HippoVecHst !== e.hip_h ||
                bus0.OutVecHst !== e.out_h || bus0.hist_count !== e.cnt || bus0.rewarded !== e.rew) begin
               fails++;
               $display("FAIL push: got edge=%0d in=%h hip=%h out=%h cnt=%0d rew=%b expected edge=%0d in=%h hip=%h out=%h cnt=%0d rew=%b",
                        edges, bus0.InVecHst, bus0.HippoVecHst, bus0.OutVecHst, bus0.hist_count, bus0.rewarded,
                        e.at_edge, e.in_h, e.hip_h, e.out_h, e.cnt, e.rew);
            end
         end
      end
   end

   task automatic step(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_push(input int unsigned dly, input logic [7:0] ei, input logic [15:0] eh,
                              input logic [7:0] eo, input logic [1:0] ec, input logic er);
      exp_t e;
      e.at_edge = edges + dly;
      e.in_h = ei; e.hip_h = eh; e.out_h = eo; e.cnt = ec; e.rew = er;
      sb.push_back(e);
   endtask

   // One full 10-cycle window: vf on the first cycle, vl on the capture cycle.
   task automatic window(input logic [15:0] vf, input logic [15:0] vl, input logic rw,
                         input logic [7:0] ei, input logic [15:0] eh, input logic [7:0] eo,
                         input logic [1:0] ec, input logic er);
      expect_push(10, ei, eh, eo, ec, er);
      bus0.NetworkOutput = vf;
      bus0.reward_in = rw;
      step(1);
      bus0.reward_in = 1'b0;
      bus0.NetworkOutput = '0;
      step(8);
      bus0.NetworkOutput = vl;
      step(1);
      bus0.NetworkOutput = '0;
   endtask

   task automatic chk_clear(input string tag);
      chk({tag, "_in"}, 64'(bus0.InVecHst), 64'h0);
      chk({tag, "_hip"}, 64'(bus0.HippoVecHst), 64'h0);
      chk({tag, "_out"}, 64'(bus0.OutVecHst), 64'h0);
      chk({tag, "_cnt"}, 64'(bus0.hist_count), 64'h0);
      chk({tag, "_rew"}, 64'(bus0.rewarded), 64'h0);
      chk({tag, "_push"}, 64'(bus0.hist_push), 64'h0);
   endtask

   initial begin
      edges = 0; tests = 0; fails = 0;
      reset = 1'b0;
      bus0.NetworkOutput = '0; bus0.reward_in = 1'b0;
      bus0.start_replay_phase = 1'b0; bus0.finish_replay_phase = 1'b0;
      bus1.NetworkOutput = '0; bus1.reward_in = 1'b0;
      bus1.start_replay_phase = 1'b0; bus1.finish_replay_phase = 1'b0;

      // Reset state
      step(3);
      chk_clear("reset");
      reset = 1'b1;

      // Single spike on neuron 0 in cycle 3 of the first window
      expect_push(10, 8'h01, 16'h0000, 8'h00, 2'd1, 1'b0);
      step(2);
      bus0.NetworkOutput = 16'h0001;
      step(1);
      bus0.NetworkOutput = '0;
      step(7);

      // Layer2 patterns A5, 3C (split across first/capture cycle), FF; count saturates
      window(16'h0A50, 16'h0000, 1'b0, 8'h10, 16'h00A5, 8'h00, 2'd2, 1'b0);
      window(16'h0300, 16'h00C0, 1'b0, 8'h00, 16'hA53C, 8'h00, 2'd2, 1'b0);
      window(16'h0FF0, 16'h0FF0, 1'b0, 8'h00, 16'h3CFF, 8'h00, 2'd2, 1'b0);

      // Freeze at wcnt=5 with spikes and a reward pulse
      bus0.NetworkOutput = 16'hF00F;
      step(5);
      bus0.start_replay_phase = 1'b1;
      bus0.reward_in = 1'b1;
      bus0.NetworkOutput = 16'hFFFF;
      step(1);
      bus0.reward_in = 1'b0;
      step(3);
      chk("freeze_in", 64'(bus0.InVecHst), 64'h00);
      chk("freeze_hip", 64'(bus0.HippoVecHst), 64'h3CFF);
      chk("freeze_out", 64'(bus0.OutVecHst), 64'h00);
      chk("freeze_cnt", 64'(bus0.hist_count), 64'd2);
      chk("freeze_rew", 64'(bus0.rewarded), 64'd0);
      bus0.start_replay_phase = 1'b0;
      bus0.NetworkOutput = '0;
      window(16'h0000, 16'h0000, 1'b0, 8'h00, 16'hFF00, 8'h00, 2'd2, 1'b0);

      // Reward latch, then finish (with reward) on the capture cycle
      bus0.reward_in = 1'b1;
      step(1);
      bus0.reward_in = 1'b0;
      chk("reward_set", 64'(bus0.rewarded), 64'd1);
      step(8);
      bus0.finish_replay_phase = 1'b1;
      bus0.reward_in = 1'b1;
      bus0.NetworkOutput = 16'hFFFF;
      step(1);
      bus0.finish_replay_phase = 1'b0;
      bus0.reward_in = 1'b0;
      bus0.NetworkOutput = '0;
      chk_clear("finish");

      // Two pushes, then asynchronous reset mid-window
      window(16'h0002, 16'h0000, 1'b0, 8'h02, 16'h0000, 8'h00, 2'd1, 1'b0);
      window(16'h0004, 16'h0000, 1'b1, 8'h24, 16'h0000, 8'h00, 2'd2, 1'b1);
      bus0.NetworkOutput = 16'hFFFF;
      step(4);
      #1 reset = 1'b0;
      #1 chk_clear("async_rst");
      bus0.NetworkOutput = '0;
      step(2);
      reset = 1'b1;

      // Full window after release; nWindow=1 instance pushes every cycle meanwhile
      expect_push(10, 8'h08, 16'h0000, 8'h00, 2'd1, 1'b0);
      bus0.NetworkOutput = 16'h0008;
      bus1.NetworkOutput = 16'h0001;
      step(1);
      bus0.NetworkOutput = '0;
      chk("w1_push1", 64'(bus1.hist_push), 64'd1);
      chk("w1_in1", 64'(bus1.InVecHst), 64'h01);
      chk("w1_cnt1", 64'(bus1.hist_count), 64'd1);
      bus1.NetworkOutput = 16'h0002;
      step(1);
      chk("w1_push2", 64'(bus1.hist_push), 64'd1);
      chk("w1_in2", 64'(bus1.InVecHst), 64'h12);
      chk("w1_cnt2", 64'(bus1.hist_count), 64'd2);
      bus1.NetworkOutput = 16'h0003;
      step(1);
      chk("w1_in3", 64'(bus1.InVecHst), 64'h23);
      chk("w1_cnt3", 64'(bus1.hist_count), 64'd2);
      bus1.NetworkOutput = '0;
      step(9);

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
